completion_arbiter: RTL and testbench

Sits directly downstream of the per-FU issue-queue/functional-unit wrappers. Collects each FU's single-cycle result beat (`fu_out_*`) into a small per-FU FIFO, then arbitrates round-robin onto one completion bus feeding PRF writeback and the ROB. Generates per-FU stall back to each issue queue so no result is ever lost, since the FUs have no output backpressure.

---
 rtl/ooo_pkg.sv | 41 ++++
 rtl/result_fifo.sv | 52 +++++
 rtl/completion_arbiter.sv | 145 ++++++++++++++
 tb/tb_completion_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared types and defaults for the out-of-order completion path.
// Holds the result-beat struct and the round-robin pick helper.
package ooo_pkg;

  localparam int INST_ID_BITS_DEF = 6;
  localparam int PRN_BITS_DEF     = 6;
  localparam int MAX_OPERANDS_DEF = 3;
  localparam int FU_COUNT_DEF     = 4;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int STALL_SLACK_DEF  = 2;
  localparam int DATA_BITS        = 64;

  typedef struct packed {
    logic [INST_ID_BITS_DEF-1:0] inst_id;
    logic [MAX_OPERANDS_DEF-1:0][PRN_BITS_DEF-1:0] prn;
    logic [MAX_OPERANDS_DEF-1:0][DATA_BITS-1:0] data;
    logic [MAX_OPERANDS_DEF-1:0] data_valid;
  } fu_result_t;

  // First set bit at or after ptr, wrapping within n requesters.
  function automatic int unsigned rr_first(
    input logic [31:0] req,
    input int unsigned ptr,
    input int unsigned n
  );
    int unsigned idx;
    logic found;
    rr_first = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (!found && req[idx]) begin
          found = 1'b1;
          rr_first = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Per-FU circular result buffer with count, full and empty.
// A push into a full buffer lands only when a pop frees a slot.
module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count_next,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0] count;
  logic do_push;
  logic do_pop;

  assign empty = (count == '0);
  assign full = (count == (AW+1)'(DEPTH));
  assign dout = mem[rd_ptr];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count_next = count
    + {{AW{1'b0}}, do_push}
    - {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/completion_arbiter.sv
// Round-robin completion arbiter: per-FU FIFOs onto one writeback bus.
// COMPLETION_ARB_BYPASS_EN adds a 0-cycle path for empty-FIFO beats.
module completion_arbiter
  import ooo_pkg::*;
#(
  parameter int INST_ID_BITS = INST_ID_BITS_DEF,
  parameter int PRN_BITS     = PRN_BITS_DEF,
  parameter int MAX_OPERANDS = MAX_OPERANDS_DEF,
  parameter int FU_COUNT     = FU_COUNT_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STALL_SLACK  = STALL_SLACK_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FU_COUNT-1:0]         fu_out_valid,
  input  logic [INST_ID_BITS-1:0]     fu_out_inst_id [FU_COUNT],
  input  logic [PRN_BITS-1:0]         fu_out_prn [FU_COUNT][MAX_OPERANDS],
  input  logic [DATA_BITS-1:0]        fu_out_data [FU_COUNT][MAX_OPERANDS],
  input  logic [MAX_OPERANDS-1:0]     fu_out_data_valid [FU_COUNT],
  output logic [FU_COUNT-1:0]         fu_stall,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [$clog2(FU_COUNT)-1:0] wb_fu_idx,
  output logic [INST_ID_BITS-1:0]     wb_inst_id,
  output logic [PRN_BITS-1:0]         wb_prn [MAX_OPERANDS],
  output logic [DATA_BITS-1:0]        wb_data [MAX_OPERANDS],
  output logic [MAX_OPERANDS-1:0]     wb_data_valid,
  output logic                        overflow_err
);

  localparam int IW = $clog2(FU_COUNT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [INST_ID_BITS-1:0] inst_id;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn;
    logic [MAX_OPERANDS-1:0][DATA_BITS-1:0] data;
    logic [MAX_OPERANDS-1:0] data_valid;
  } beat_t;

  beat_t in_beat [FU_COUNT];
  beat_t head [FU_COUNT];
  beat_t sel;
  logic [CW-1:0] cnt_nxt [FU_COUNT];
  logic [FU_COUNT-1:0] empty;
  logic [FU_COUNT-1:0] full;
  logic [FU_COUNT-1:0] push;
  logic [FU_COUNT-1:0] pop;
  logic [FU_COUNT-1:0] cand;
  logic [FU_COUNT-1:0] stall_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] win_nxt;
  logic [IW-1:0] lock_idx;
  logic lock_q;
  logic any;
  logic byp;
  logic accept;
  logic ovf_hit;

  always_comb begin
    for (int g = 0; g < FU_COUNT; g++) begin
      in_beat[g].inst_id = fu_out_inst_id[g];
      in_beat[g].data_valid = fu_out_data_valid[g];
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        in_beat[g].prn[k] = fu_out_prn[g][k];
        in_beat[g].data[k] = fu_out_data[g][k];
      end
    end
  end

  for (genvar g = 0; g < FU_COUNT; g++) begin : g_fifo
    result_fifo #(
      .W($bits(beat_t)),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk(clk),
      .rst_n(rst),
      .push(push[g]),
      .pop(pop[g]),
      .din(in_beat[g]),
      .dout(head[g]),
      .count_next(cnt_nxt[g]),
      .full(full[g]),
      .empty(empty[g])
    );
  end

  always_comb begin
    cand = ~empty;
`ifdef COMPLETION_ARB_BYPASS_EN
    cand = cand | fu_out_valid;
`endif
    any = |cand;
    win = lock_q ? lock_idx
      : IW'(rr_first(32'(cand), 32'(rr_ptr), FU_COUNT));
    wb_valid = lock_q || any;
    byp = 1'b0;
`ifdef COMPLETION_ARB_BYPASS_EN
    byp = !lock_q && empty[win] && fu_out_valid[win];
`endif
    sel = byp ? in_beat[win] : head[win];
    if (!wb_valid) sel = '0;
    accept = wb_valid && wb_ready;
    win_nxt = (win == IW'(FU_COUNT - 1)) ? '0 : win + IW'(1);
    // A bypassed beat that is accepted never enters its FIFO.
    push = fu_out_valid;
    pop = '0;
    if (accept) begin
      if (byp) push[win] = 1'b0;
      else pop[win] = 1'b1;
    end
    ovf_hit = |(push & full & ~pop);
  end

  always_comb begin
    wb_fu_idx = wb_valid ? win : '0;
    wb_inst_id = sel.inst_id;
    wb_data_valid = sel.data_valid;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      wb_prn[k] = sel.prn[k];
      wb_data[k] = sel.data[k];
    end
    for (int g = 0; g < FU_COUNT; g++) begin
      stall_nxt[g] = (CW'(FIFO_DEPTH) - cnt_nxt[g]) < CW'(STALL_SLACK);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      lock_q <= 1'b0;
      lock_idx <= '0;
      fu_stall <= '0;
      overflow_err <= 1'b0;
    end else begin
      lock_q <= wb_valid && !wb_ready;
      lock_idx <= win;
      if (accept) rr_ptr <= win_nxt;
      fu_stall <= stall_nxt;
      if (ovf_hit) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_completion_arbiter.sv
// Directed self-checking bench for completion_arbiter.
// Bypass-only steps are enabled by COMPLETION_ARB_BYPASS_EN.
module tb_completion_arbiter;

  logic clk;
  logic rst;
  logic [3:0] fu_out_valid;
  logic [5:0] fu_out_inst_id [4];
  logic [5:0] fu_out_prn [4][3];
  logic [63:0] fu_out_data [4][3];
  logic [2:0] fu_out_data_valid [4];
  logic [3:0] fu_stall;
  logic wb_valid;
  logic wb_ready;
  logic [1:0] wb_fu_idx;
  logic [5:0] wb_inst_id;
  logic [5:0] wb_prn [3];
  logic [63:0] wb_data [3];
  logic [2:0] wb_data_valid;
  logic overflow_err;

  int n_cmp = 0;
  int n_err = 0;

  completion_arbiter dut (
    .clk(clk),
    .rst(rst),
    .fu_out_valid(fu_out_valid),
    .fu_out_inst_id(fu_out_inst_id),
    .fu_out_prn(fu_out_prn),
    .fu_out_data(fu_out_data),
    .fu_out_data_valid(fu_out_data_valid),
    .fu_stall(fu_stall),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_fu_idx(wb_fu_idx),
    .wb_inst_id(wb_inst_id),
    .wb_prn(wb_prn),
    .wb_data(wb_data),
    .wb_data_valid(wb_data_valid),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input int id);
    chk({tag, "_v"}, 64'(wb_valid), 64'd1);
    chk({tag, "_idx"}, 64'(wb_fu_idx), 64'(idx));
    chk({tag, "_id"}, 64'(wb_inst_id), 64'(id));
    chk({tag, "_d"}, wb_data[0], 64'hD000 + 64'(id));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    fu_out_valid = '0;
    for (int f = 0; f < 4; f++) begin
      fu_out_inst_id[f] = '0;
      fu_out_data_valid[f] = '0;
      for (int k = 0; k < 3; k++) begin
        fu_out_prn[f][k] = '0;
        fu_out_data[f][k] = '0;
      end
    end
  endtask

  task automatic drive(input int fu, input int id);
    fu_out_valid[fu] = 1'b1;
    fu_out_inst_id[fu] = 6'(id);
    fu_out_prn[fu][0] = 6'(id);
    fu_out_data[fu][0] = 64'hD000 + 64'(id);
    fu_out_data_valid[fu] = 3'b001;
  endtask

  initial begin
    rst = 1'b0;
    wb_ready = 1'b0;
    clr();
    step();
    step();
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_id", 64'(wb_inst_id), 64'd0);
    chk("rst_stall", 64'(fu_stall), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
    rst = 1'b1;

    // all four FUs at once: grants 0,1,2,3 from rr_ptr 0
    step();
    for (int f = 0; f < 4; f++) drive(f, 10 + f);
    #1;
    step();
    clr();
    wb_ready = 1'b1;
    #1;
    chk_beat("rr0", 0, 10);
    for (int f = 1; f < 4; f++) begin
      step();
      #1;
      chk_beat($sformatf("rr%0d", f), f, 10 + f);
    end
    step();
    #1;
    chk("rr_idle", 64'(wb_valid), 64'd0);

    // single beat on FU2, rr_ptr back at 0
    wb_ready = 1'b0;
    drive(2, 5);
    fu_out_prn[2][0] = 6'd7;
    fu_out_data[2][0] = 64'hDEAD;
    #1;
`ifndef COMPLETION_ARB_BYPASS_EN
    chk("lat_push_cyc", 64'(wb_valid), 64'd0);
`endif
    step();
    clr();
    wb_ready = 1'b1;
    #1;
    chk("one_v", 64'(wb_valid), 64'd1);
    chk("one_idx", 64'(wb_fu_idx), 64'd2);
    chk("one_id", 64'(wb_inst_id), 64'd5);
    chk("one_prn", 64'(wb_prn[0]), 64'd7);
    chk("one_data", wb_data[0], 64'hDEAD);
    chk("one_dv", 64'(wb_data_valid), 64'b001);
    step();
    #1;
    chk("one_only", 64'(wb_valid), 64'd0);

    // rr_ptr=3: FU3 before FU1; FU3 beat has no valid slots
    wb_ready = 1'b0;
    drive(1, 15);
    drive(3, 16);
    fu_out_data_valid[3] = 3'b000;
    #1;
    step();
    clr();
    wb_ready = 1'b1;
    #1;
    chk_beat("wrap3", 3, 16);
    chk("store_dv", 64'(wb_data_valid), 64'd0);
    step();
    #1;
    chk_beat("wrap1", 1, 15);
    step();
    #1;
    chk("wrap_idle", 64'(wb_valid), 64'd0);

    // lock on FU1 (rr_ptr=2) while FU0 also becomes ready
    wb_ready = 1'b0;
    drive(1, 20);
    #1;
    step();
    clr();
    drive(0, 21);
    #1;
    chk_beat("lock_a", 1, 20);
    step();
    clr();
    drive(1, 22);
    #1;
    chk_beat("lock_b", 1, 20);
    step();
    clr();
    drive(1, 23);
    #1;
    chk_beat("lock_c", 1, 20);
    chk("stall_cnt2", 64'(fu_stall[1]), 64'd0);
    step();
    clr();
    #1;
    chk("stall_cnt3", 64'(fu_stall[1]), 64'd1);
    chk("stall_fu0", 64'(fu_stall[0]), 64'd0);
    wb_ready = 1'b1;
    #1;
    chk_beat("lock_d", 1, 20);
    step();
    #1;
    chk_beat("post_lock0", 0, 21);
    chk("stall_rel", 64'(fu_stall[1]), 64'd0);
    step();
    #1;
    chk_beat("post_lock1", 1, 22);
    step();
    #1;
    chk_beat("post_lock2", 1, 23);
    step();
    #1;
    chk("lock_idle", 64'(wb_valid), 64'd0);

    // FU0 overflow: fifth beat into a full FIFO is dropped
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 30 + i);
      #1;
      step();
    end
    drive(0, 34);
    #1;
    chk("stall_full", 64'(fu_stall[0]), 64'd1);
    chk("ovf_pre", 64'(overflow_err), 64'd0);
    chk_beat("ovf_head", 0, 30);
    step();
    clr();
    #1;
    chk("ovf_set", 64'(overflow_err), 64'd1);
    wb_ready = 1'b1;
    #1;
    chk_beat("ovf_q0", 0, 30);
    for (int i = 1; i < 4; i++) begin
      step();
      #1;
      chk_beat($sformatf("ovf_q%0d", i), 0, 30 + i);
    end
    step();
    #1;
    chk("ovf_drop", 64'(wb_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow_err), 64'd1);

    // full FIFO with push and pop in the same cycle
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 40 + i);
      #1;
      step();
    end
    drive(0, 44);
    wb_ready = 1'b1;
    #1;
    chk_beat("pp0", 0, 40);
    for (int i = 1; i < 5; i++) begin
      step();
      clr();
      #1;
      chk_beat($sformatf("pp%0d", i), 0, 40 + i);
      if (i == 1) chk("pp_stall", 64'(fu_stall[0]), 64'd1);
    end
    step();
    #1;
    chk("pp_idle", 64'(wb_valid), 64'd0);

    // reset with three entries queued on FU3
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3, 50 + i);
      #1;
      step();
    end
    clr();
    #1;
    chk("pre_rst_stall", 64'(fu_stall[3]), 64'd1);
    chk("pre_rst_v", 64'(wb_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_v", 64'(wb_valid), 64'd0);
    chk("mid_rst_id", 64'(wb_inst_id), 64'd0);
    chk("mid_rst_idx", 64'(wb_fu_idx), 64'd0);
    chk("mid_rst_stall", 64'(fu_stall), 64'd0);
    chk("mid_rst_ovf", 64'(overflow_err), 64'd0);
    step();
    step();
    rst = 1'b1;
    wb_ready = 1'b1;
    step();
    #1;
    chk("no_stale_a", 64'(wb_valid), 64'd0);
    step();
    #1;
    chk("no_stale_b", 64'(wb_valid), 64'd0);

    // rr_ptr restarted at 0: FU1 before FU2
    wb_ready = 1'b0;
    drive(2, 56);
    drive(1, 55);
    #1;
    step();
    clr();
    wb_ready = 1'b1;
    #1;
    chk_beat("rst_rr1", 1, 55);
    step();
    #1;
    chk_beat("rst_rr2", 2, 56);
    step();
    #1;
    chk("rst_rr_idle", 64'(wb_valid), 64'd0);

`ifdef COMPLETION_ARB_BYPASS_EN
    drive(3, 60);
    #1;
    chk_beat("byp", 3, 60);
    step();
    clr();
    #1;
    chk("byp_empty", 64'(wb_valid), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
